// File: rtl/framed_serializer.sv
// Word-to-bit-stream serializer: valid/ready word intake, MSB- or LSB-first output,
// each bit held CLKS_PER_BIT clocks, gapless back-to-back words.
package framed_serializer_pkg;
  typedef enum logic {MSB_FIRST = 1'b0, LSB_FIRST = 1'b1} shift_direction_t;
endpackage

module framed_serializer
  import framed_serializer_pkg::*;
#(
  parameter int   N            = 8,
  parameter int   CLKS_PER_BIT = 1,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  shift_direction_t direction,
  input  logic [N-1:0]     i_data,
  output logic             out,
  output logic             o_active,
  output logic             o_last,
  output logic [N-1:0]     q
);
  localparam int BW = $clog2(N);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(N - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    bit_idx;
  logic [TW-1:0]    tick;
  shift_direction_t dir;
  logic             bit_done, word_done, accept;

  assign bit_done  = (tick == LAST_TICK);
  assign word_done = (state == SHIFT) && bit_done && (bit_idx == LAST_BIT);
  assign accept    = i_valid && o_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (word_done && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is asserted, independent of the registers.
  always_comb begin
    o_ready  = 1'b0;
    o_active = 1'b0;
    o_last   = 1'b0;
    out      = IDLE_LEVEL;
    if (!rst) begin
      case (state)
        IDLE: o_ready = 1'b1;
        SHIFT: begin
          o_active = 1'b1;
          o_last   = word_done;
          o_ready  = word_done;
          out      = (dir == LSB_FIRST) ? q[0] : q[N-1];
        end
        default: ;
      endcase
    end
  end

  // The final bit also shifts, so q drains to zero once a word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      bit_idx <= '0;
      tick    <= '0;
      dir     <= MSB_FIRST;
    end else if (accept) begin
      q       <= i_data;
      dir     <= direction;
      bit_idx <= '0;
      tick    <= '0;
    end else if (state == SHIFT) begin
      if (!bit_done) begin
        tick <= tick + 1'b1;
      end else begin
        tick    <= '0;
        bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
        case (dir)
          MSB_FIRST: q <= q << 1;
          LSB_FIRST: q <= q >> 1;
          default:   q <= q;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_framed_serializer.sv
// Bench for framed_serializer: two instances (1 and 3 clocks per bit) share stimulus and are
// compared each cycle against a cycle-count model of the word timeline.
module tb_framed_serializer;
  import framed_serializer_pkg::*;

  localparam int N = 8;

  logic             clk = 1'b0;
  logic             rst, i_valid;
  logic [7:0]       i_data;
  shift_direction_t direction;
  logic [1:0]       rdy, act, lst, so;
  logic [7:0]       q0, q1;

  int n_cmp = 0;
  int n_bad = 0;

  int               rem   [2] = '{0, 0};
  int               kk    [2] = '{1, 3};
  logic [7:0]       mword [2];
  shift_direction_t mdir  [2];

  framed_serializer #(.N(N), .CLKS_PER_BIT(1), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy[0]), .direction(direction),
    .i_data(i_data), .out(so[0]), .o_active(act[0]), .o_last(lst[0]), .q(q0));

  framed_serializer #(.N(N), .CLKS_PER_BIT(3), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy[1]), .direction(direction),
    .i_data(i_data), .out(so[1]), .o_active(act[1]), .o_last(lst[1]), .q(q1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected {ready, active, last, out, q}: rem counts cycles left in the current word.
  function automatic logic [11:0] model_exp(int d);
    int pos, b;
    logic [7:0] qv;
    if (rem[d] == 0) return {~rst, 3'b000, 8'h00};
    pos = N * kk[d] - rem[d];
    b   = pos / kk[d];
    qv  = (mdir[d] == MSB_FIRST) ? (mword[d] << b) : (mword[d] >> b);
    if (rst) return {4'b0000, qv};
    return {rem[d] == 1, 1'b1, rem[d] == 1,
            (mdir[d] == MSB_FIRST) ? mword[d][N-1-b] : mword[d][b], qv};
  endfunction

  function automatic logic [11:0] obs(int d);
    return {rdy[d], act[d], lst[d], so[d], (d == 0) ? q0 : q1};
  endfunction

  task automatic drive(input logic r, input logic v, input logic [7:0] dat,
                       input shift_direction_t dr);
    rst = r; i_valid = v; i_data = dat; direction = dr;
    #1;
  endtask

  task automatic advance();
    logic mready;
    for (int d = 0; d < 2; d++) begin
      mready = !rst && (rem[d] <= 1);
      if (rst) rem[d] = 0;
      else if (mready && i_valid) begin
        mword[d] = i_data; mdir[d] = direction; rem[d] = N * kk[d];
      end else if (rem[d] > 0) rem[d]--;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 8'hA5, MSB_FIRST);
    n_cmp++;
    if ({rdy, act, lst, so} !== 8'h00) begin
      n_bad++; $display("FAIL reset_outputs got %h want 00", {rdy, act, lst, so});
    end
    advance();
    drive(1'b0, 1'b0, 8'h00, MSB_FIRST);
    n_cmp++;
    if (rdy !== 2'b11 || act !== 2'b00 || so !== 2'b00 || q0 !== 8'h00 || q1 !== 8'h00) begin
      n_bad++; $display("FAIL reset_idle got rdy=%b act=%b out=%b q0=%h q1=%h want 11 00 00 00 00",
                        rdy, act, so, q0, q1);
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs(d) !== model_exp(d)) begin
        n_bad++; $display("FAIL reset_model dut%0d got %h want %h", d, obs(d), model_exp(d));
      end
    end
    advance();
  endtask

  task automatic test_single_word(input shift_direction_t dr);
    logic [7:0] w = 8'hB4;
    drive(1'b1, 1'b0, 8'h00, MSB_FIRST); advance();
    drive(1'b0, 1'b1, w, dr); advance();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 8'h00, (dr == MSB_FIRST) ? LSB_FIRST : MSB_FIRST);
      n_cmp++;
      if (so[0] !== ((dr == MSB_FIRST) ? w[7-c] : w[c]) || lst[0] !== (c == 7) || act[0] !== 1'b1) begin
        n_bad++; $display("FAIL single_word dir=%0d bit%0d got out=%b last=%b act=%b",
                          dr, c, so[0], lst[0], act[0]);
      end
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== model_exp(d)) begin
          n_bad++; $display("FAIL single_word_model dut%0d got %h want %h", d, obs(d), model_exp(d));
        end
      end
      advance();
    end
    drive(1'b0, 1'b0, 8'h00, MSB_FIRST);
    n_cmp++;
    if (act[0] !== 1'b0 || so[0] !== 1'b0 || rdy[0] !== 1'b1 || q0 !== 8'h00) begin
      n_bad++; $display("FAIL single_word_end got act=%b out=%b rdy=%b q=%h want 0 0 1 00",
                        act[0], so[0], rdy[0], q0);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [15:0] s = 16'hB40F;
    logic ends;
    drive(1'b1, 1'b0, 8'h00, MSB_FIRST); advance();
    drive(1'b0, 1'b1, 8'hB4, MSB_FIRST); advance();
    for (int c = 1; c <= 48; c++) begin
      drive(1'b0, c <= 24, 8'h0F, MSB_FIRST);
      ends = (c == 24) || (c == 48);
      n_cmp++;
      if (so[1] !== s[15-(c-1)/3] || act[1] !== 1'b1 || rdy[1] !== ends || lst[1] !== ends) begin
        n_bad++; $display("FAIL back_to_back cyc%0d got out=%b act=%b rdy=%b last=%b want out=%b 1 %b %b",
                          c, so[1], act[1], rdy[1], lst[1], s[15-(c-1)/3], ends, ends);
      end
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== model_exp(d)) begin
          n_bad++; $display("FAIL back_to_back_model dut%0d got %h want %h", d, obs(d), model_exp(d));
        end
      end
      advance();
    end
    drive(1'b0, 1'b0, 8'h00, MSB_FIRST);
    n_cmp++;
    if (act[1] !== 1'b0 || so[1] !== 1'b0) begin
      n_bad++; $display("FAIL back_to_back_end got act=%b out=%b want 0 0", act[1], so[1]);
    end
    advance();
  endtask

  task automatic test_direction_change();
    logic [7:0] w = 8'hB4;
    drive(1'b1, 1'b0, 8'h00, MSB_FIRST); advance();
    drive(1'b0, 1'b1, w, MSB_FIRST); advance();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, (c == 2) || (c == 3), (c >= 2) ? 8'hFF : w, (c >= 2) ? LSB_FIRST : MSB_FIRST);
      n_cmp++;
      if (so[0] !== w[7-c]) begin
        n_bad++; $display("FAIL direction_change bit%0d got %b want %b", c, so[0], w[7-c]);
      end
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== model_exp(d)) begin
          n_bad++; $display("FAIL direction_change_model dut%0d got %h want %h", d, obs(d), model_exp(d));
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w = 8'h81;
    drive(1'b1, 1'b0, 8'h00, MSB_FIRST); advance();
    drive(1'b0, 1'b1, 8'hB4, MSB_FIRST); advance();
    for (int c = 0; c < 4; c++) begin drive(1'b0, 1'b0, 8'h00, MSB_FIRST); advance(); end
    drive(1'b1, 1'b0, 8'h00, MSB_FIRST);
    n_cmp++;
    if (act[0] !== 1'b0 || rdy[0] !== 1'b0 || so[0] !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_during got act=%b rdy=%b out=%b want 0 0 0", act[0], rdy[0], so[0]);
    end
    advance();
    drive(1'b0, 1'b1, w, MSB_FIRST);
    n_cmp++;
    if (act[0] !== 1'b0 || rdy[0] !== 1'b1 || so[0] !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_after got act=%b rdy=%b out=%b want 0 1 0", act[0], rdy[0], so[0]);
    end
    advance();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 8'h00, MSB_FIRST);
      n_cmp++;
      if (so[0] !== w[7-c] || lst[0] !== (c == 7)) begin
        n_bad++; $display("FAIL mid_reset_word bit%0d got out=%b last=%b want %b %b",
                          c, so[0], lst[0], w[7-c], c == 7);
      end
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== model_exp(d)) begin
          n_bad++; $display("FAIL mid_reset_model dut%0d got %h want %h", d, obs(d), model_exp(d));
        end
      end
      advance();
    end
  endtask

  task automatic test_valid_during_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 8'hDA, MSB_FIRST);
      n_cmp++;
      if (rdy !== 2'b00 || act !== 2'b00) begin
        n_bad++; $display("FAIL valid_in_reset cyc%0d got rdy=%b act=%b want 00 00", c, rdy, act);
      end
      advance();
    end
    drive(1'b0, 1'b1, 8'hDA, MSB_FIRST);
    n_cmp++;
    if (rdy !== 2'b11) begin
      n_bad++; $display("FAIL valid_after_reset got rdy=%b want 11", rdy);
    end
    advance();
    drive(1'b0, 1'b0, 8'h00, MSB_FIRST);
    n_cmp++;
    if (act !== 2'b11 || so !== 2'b11 || q0 !== 8'hDA) begin
      n_bad++; $display("FAIL first_accept got act=%b out=%b q=%h want 11 11 da", act, so, q0);
    end
    advance();
  endtask

  task automatic test_random();
    drive(1'b1, 1'b0, 8'h00, MSB_FIRST); advance();
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
            shift_direction_t'($urandom_range(0, 1)));
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== model_exp(d)) begin
          n_bad++; $display("FAIL random cyc%0d dut%0d got %h want %h", c, d, obs(d), model_exp(d));
        end
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; direction = MSB_FIRST;
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00, MSB_FIRST); advance();
    test_reset();
    test_single_word(MSB_FIRST);
    test_single_word(LSB_FIRST);
    test_back_to_back();
    test_direction_change();
    test_reset_mid_word();
    test_valid_during_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/framed_serializer.md
Name: framed_serializer

Overview:
- Parametrised successor to the team's fixed 4-bit parallel-to-serial shifter.
- Accepts N-bit words over a valid/ready handshake and shifts them out one bit at a time, MSB-first or LSB-first.
- Each bit is held for a programmable number of clocks, and a new word can start with no gap when the next word is already waiting.
- Feeds bit-serial links (SPI-like data lines, LED/shift-register chains) from a word-oriented producer.

Parameters:
N, 8, word width in bits; legal range N >= 2.
CLKS_PER_BIT, 1, clock cycles each bit is held on out; legal range >= 1.
IDLE_LEVEL, 1'b0, value driven on out when no word is being shifted.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
i_valid  input  1  producer has a word on i_data.
o_ready  output  1  block can accept a word this cycle.
direction  input  shift_direction_t_ (1)  MSB_FIRST=0 or LSB_FIRST=1; sampled only on accept.
i_data  input  N  word to serialise.
out  output  1  serial bit.
o_active  output  1  high while a word is being shifted.
o_last  output  1  high during the final cycle of the final bit of a word.
q  output  N  internal shift register, exposed for debug.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. While rst is high at a rising edge, all state returns to reset values and i_valid is ignored.
- Reset values: state=IDLE, q=0, bit index=0, tick counter=0, latched direction=MSB_FIRST.
- Outputs while rst is high: o_ready=0, o_active=0, o_last=0, out=IDLE_LEVEL.
- States: IDLE and SHIFT.
- IDLE:
  - o_ready=1, o_active=0, o_last=0, out=IDLE_LEVEL.
  - Accept occurs at a rising edge with i_valid && o_ready.
  - On accept: q<=i_data, latched direction<=direction, bit index<=0, tick<=0, next state=SHIFT.
- SHIFT:
  - o_active=1.
  - out = q[N-1] if latched direction is MSB_FIRST, otherwise q[0]. out is combinational from q and the latched direction.
  - The tick counter runs 0..CLKS_PER_BIT-1.
  - If tick < CLKS_PER_BIT-1: tick increments and q holds.
  - If tick == CLKS_PER_BIT-1 and bit index < N-1: tick<=0 and bit index increments.
  - Shift on that edge: MSB_FIRST does q<=q<<1 with 0 filling bit 0; LSB_FIRST does q<=q>>1 with 0 filling bit N-1.
  - If tick == CLKS_PER_BIT-1 and bit index == N-1: o_last=1 and o_ready=1, both combinational.
    - If i_valid is high, the next word is accepted exactly as from IDLE and the state stays SHIFT. There is no idle cycle between words.
    - If i_valid is low, next state=IDLE.
  - o_ready=0 in every other SHIFT cycle. i_valid there is ignored and i_data is not captured.
- Latency and timing:
  - A word accepted at edge E drives bit i on out for cycles E+1+i*CLKS_PER_BIT through E+(i+1)*CLKS_PER_BIT.
  - Each bit is held exactly CLKS_PER_BIT cycles; a word occupies N*CLKS_PER_BIT cycles.
- Direction changes on the direction input after accept have no effect on the word in flight.
- The producer may change i_data or drop i_valid freely while o_ready=0. No data is lost, because capture happens only on an accept edge.
- CLKS_PER_BIT=1:
  - o_last is high during the single cycle of bit N-1.
  - The tick counter is constant 0 and is sized at minimum 1 bit.
- Counter widths:
  - Bit index is $clog2(N) bits.
  - Tick counter is max(1,$clog2(CLKS_PER_BIT)) bits.
  - Comparisons are unsigned. There is no wrap beyond the defined maxima.
- Reset mid-word: the word is aborted and out returns to IDLE_LEVEL in the cycle after the reset edge. Nothing is resumed.
- The default branch of any case on direction holds q.

Test Plan:
1. N=8, CLKS_PER_BIT=1, MSB_FIRST, accept 0xB4 -> out = 1,0,1,1,0,1,0,0 on 8 consecutive cycles. o_last on the 8th cycle; o_active then drops and out=IDLE_LEVEL.
2. Same word with LSB_FIRST -> out = 0,0,1,0,1,1,0,1. q shifts right with zero fill and reads 0x00 after the final shift.
3. CLKS_PER_BIT=3, i_valid held high with 0xB4 then 0x0F (MSB_FIRST):
   - out holds each bit for 3 cycles across 48 contiguous cycles.
   - o_ready and o_last are high only on cycles 24 and 48; o_active never drops between words.
4. Accept 0xB4 MSB_FIRST, then toggle direction to LSB_FIRST and change i_data to 0xFF at bit 2 -> serial stream is unchanged; 0xFF is not captured.
5. Assert rst for one cycle during bit 4 -> next cycle state is IDLE, out=IDLE_LEVEL, o_ready=1. A new word 0x81 then serialises correctly from bit 0.
6. Hold i_valid high while rst is high for 3 cycles -> no accept occurs, o_ready=0 throughout. The accept happens on the first edge after rst falls.
